// File: rtl/ms_timer_pkg.sv
// Shared types and constants for the millisecond timer scheduler.
package ms_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_WAITING = 2'd2
   } slot_state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_SLEEP = 1'b1;

   // Deadlines stay within half the 32-bit ring so the signed expiry test is unambiguous.
   localparam logic [31:0] MAX_SLEEP_MS = 32'h7FFF_FFFF;

   function automatic logic [31:0] clamp_sleep(input logic [31:0] arg);
      return (arg > MAX_SLEEP_MS) ? MAX_SLEEP_MS : arg;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond time base: divides the clock by CLOCK_RATIO and keeps a free-running ms count.
module ms_tick_gen #(
   parameter int CLOCK_RATIO = 200000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        tick,
   output logic [31:0] now_ms
);

   localparam int            CW       = (CLOCK_RATIO > 1) ? $clog2(CLOCK_RATIO) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLOCK_RATIO - 1);

   logic [CW-1:0] cyc_cnt_q;
   logic [31:0]   now_ms_q;

   assign tick   = (cyc_cnt_q == CNT_LAST);
   assign now_ms = now_ms_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cyc_cnt_q <= '0;
         now_ms_q  <= '0;
      end else if (tick) begin
         cyc_cnt_q <= '0;
         now_ms_q  <= now_ms_q + 32'd1;
      end else begin
         cyc_cnt_q <= cyc_cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/ms_timer_scheduler.sv
// Per-slot READ/SLEEP service on a shared millisecond time base with round-robin grant.
//   state      | meaning
//   ST_IDLE    | slot free, accepts a start pulse
//   ST_PENDING | op/arg latched, waiting for the round-robin grant
//   ST_WAITING | SLEEP armed, waiting for now_ms to reach the deadline
module ms_timer_scheduler
   import ms_timer_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CLOCK_RATIO = 200000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     start_port,
   input  logic [NUM_REQ-1:0]     op_port,
   input  logic [32*NUM_REQ-1:0]  arg_port,
   output logic [NUM_REQ-1:0]     done_port,
   output logic [32*NUM_REQ-1:0]  return_port,
   output logic [31:0]            now_ms
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   slot_state_t state_q [NUM_REQ];
   slot_state_t state_d [NUM_REQ];

   logic [NUM_REQ-1:0]        op_q, op_d;
   logic [NUM_REQ-1:0]        armed_q, armed_d;
   logic [NUM_REQ-1:0]        done_d;
   logic [NUM_REQ-1:0]        expire;
   logic [NUM_REQ-1:0][31:0]  arg_q, arg_d;
   logic [NUM_REQ-1:0][31:0]  deadline_q, deadline_d;
   logic [NUM_REQ-1:0][31:0]  ret_q, ret_d;
   logic [PW-1:0]             rr_q, rr_d;
   logic [PW-1:0]             grant_idx;
   logic [PW-1:0]             cand;
   logic                      grant_vld;
   logic                      tick;
   logic                      tick_q;

   ms_tick_gen #(
      .CLOCK_RATIO (CLOCK_RATIO)
   ) u_tick_gen (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .now_ms (now_ms)
   );

   assign return_port = ret_q;

   // A waiting slot can only newly expire when now_ms has just advanced or it was just armed.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_expiry
      logic [31:0] since_dl;
      assign since_dl  = now_ms - deadline_q[g];
      assign expire[g] = (state_q[g] == ST_WAITING) && (tick_q || armed_q[g]) && !since_dl[31];
   end

   always_comb begin
      int idx;
      idx       = 0;
      cand      = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = PW'(idx);
         if (!grant_vld && state_q[cand] == ST_PENDING) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      rr_d       = rr_q;
      done_d     = '0;
      armed_d    = '0;
      op_d       = op_q;
      arg_d      = arg_q;
      deadline_d = deadline_q;
      ret_d      = ret_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            ST_IDLE: begin
               if (start_port[i]) begin
                  state_d[i] = ST_PENDING;
                  op_d[i]    = op_port[i];
                  arg_d[i]   = arg_port[32*i +: 32];
               end
            end
            ST_PENDING: begin
               if (grant_vld && grant_idx == PW'(i)) begin
                  if (op_q[i] == OP_READ) begin
                     done_d[i]  = 1'b1;
                     ret_d[i]   = now_ms;
                     state_d[i] = ST_IDLE;
                  end else begin
                     deadline_d[i] = now_ms + clamp_sleep(arg_q[i]);
                     armed_d[i]    = 1'b1;
                     state_d[i]    = ST_WAITING;
                  end
               end
            end
            ST_WAITING: begin
               if (expire[i]) begin
                  done_d[i]  = 1'b1;
                  ret_d[i]   = now_ms;
                  state_d[i] = ST_IDLE;
               end
            end
            default: state_d[i] = ST_IDLE;
         endcase
      end
      if (grant_vld) begin
         rr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) state_q[i] <= ST_IDLE;
         op_q       <= '0;
         arg_q      <= '0;
         armed_q    <= '0;
         deadline_q <= '0;
         ret_q      <= '0;
         done_port  <= '0;
         rr_q       <= '0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         armed_q    <= armed_d;
         deadline_q <= deadline_d;
         ret_q      <= ret_d;
         done_port  <= done_d;
         rr_q       <= rr_d;
         tick_q     <= tick;
      end
   end

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Directed bench for ms_timer_scheduler with NUM_REQ=4, CLOCK_RATIO=10.
module tb_ms_timer_scheduler;

   logic         clock;
   logic         reset;
   logic [3:0]   start_port;
   logic [3:0]   op_port;
   logic [127:0] arg_port;
   logic [3:0]   done_port;
   logic [127:0] return_port;
   logic [31:0]  now_ms;

   int checks = 0;
   int errors = 0;
   int k      = 0;

   ms_timer_scheduler #(
      .NUM_REQ     (4),
      .CLOCK_RATIO (10)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start_port  (start_port),
      .op_port     (op_port),
      .arg_port    (arg_port),
      .done_port   (done_port),
      .return_port (return_port),
      .now_ms      (now_ms)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
      k++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input logic [3:0] mask, input int budget,
                            output logic [3:0] seen);
      seen = '0;
      for (int i = 0; i < budget; i++) begin
         step();
         if ((done_port & mask) != 4'b0) begin
            seen = done_port;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s: no done within %0d cycles, got done %b expected mask %b",
               tag, budget, done_port, mask);
   endtask

   task automatic quiet_count(input logic [3:0] mask, input int until_k, output int cnt);
      cnt = 0;
      while (k < until_k) begin
         step();
         if ((done_port & mask) != 4'b0) cnt++;
      end
   endtask

   initial begin
      logic [3:0] seen;
      int         cnt;

      reset      = 1'b0;
      start_port = '0;
      op_port    = '0;
      arg_port   = '0;
      repeat (3) @(negedge clock);
      start_port[1] = 1'b1;
      @(negedge clock);
      start_port = '0;
      @(negedge clock);
      reset = 1'b1;
      k     = 0;

      chk("rst_now_ms", now_ms, 0);
      chk("rst_done", done_port, 0);
      chk("rst_return", return_port, 0);

      // all four READ together: strict order, then slots 3 and 0 together
      start_port = 4'hF;
      op_port    = 4'h0;
      step();
      start_port = '0;
      chk("rd_all_k1", done_port, 4'b0000);
      step(); chk("rd_all_s0", done_port, 4'b0001);
      step(); chk("rd_all_s1", done_port, 4'b0010);
      step(); chk("rd_all_s2", done_port, 4'b0100);
      step(); chk("rd_all_s3", done_port, 4'b1000);
      start_port = 4'b1001;
      step();
      start_port = '0;
      chk("rd_30_k6", done_port, 4'b0000);
      step(); chk("rd_30_first", done_port, 4'b0001);
      step(); chk("rd_30_second", done_port, 4'b1000);

      // uncontended READ at now_ms=5
      while (k < 50) step();
      start_port[0] = 1'b1;
      op_port[0]    = 1'b0;
      step();
      start_port = '0;
      chk("rd5_early", done_port, 4'b0000);
      step();
      chk("rd5_done", done_port, 4'b0001);
      chk("rd5_ret", return_port[31:0], 32'd5);
      step();
      chk("rd5_single", done_port, 4'b0000);

      // SLEEP 3 granted at now_ms=7: detection at k=100, done at k=101
      while (k < 70) step();
      start_port[1]       = 1'b1;
      op_port[1]          = 1'b1;
      arg_port[32 +: 32]  = 32'd3;
      step();
      start_port = '0;
      wait_done("sleep3", 4'b0010, 60, seen);
      chk("sleep3_k", k, 101);
      chk("sleep3_ret", return_port[63:32], 32'd10);

      // SLEEP 0 started in the previous done cycle: done 3 cycles later
      start_port[1]      = 1'b1;
      op_port[1]         = 1'b1;
      arg_port[32 +: 32] = 32'd0;
      step();
      start_port = '0;
      wait_done("sleep0", 4'b0010, 10, seen);
      chk("sleep0_k", k, 104);
      chk("sleep0_ret", return_port[63:32], 32'd10);

      // slots 0 and 2 to deadline 16; extra start on slot 0 while waiting
      while (k < 110) step();
      start_port          = 4'b0101;
      op_port             = 4'b0101;
      arg_port[0 +: 32]   = 32'd5;
      arg_port[64 +: 32]  = 32'd5;
      step();
      start_port = '0;
      while (k < 120) step();
      start_port[0]     = 1'b1;
      op_port[0]        = 1'b1;
      arg_port[0 +: 32] = 32'd1;
      step();
      start_port = '0;
      wait_done("same_dl", 4'b0101, 80, seen);
      chk("same_dl_both", seen, 4'b0101);
      chk("same_dl_k", k, 161);
      chk("same_dl_ret0", return_port[31:0], 32'd16);
      chk("same_dl_ret2", return_port[95:64], 32'd16);
      quiet_count(4'b0001, 181, cnt);
      chk("same_dl_single", cnt, 0);

      // reset while slot 2 waits
      start_port[2]      = 1'b1;
      op_port[2]         = 1'b1;
      arg_port[64 +: 32] = 32'd2;
      step();
      start_port = '0;
      repeat (4) step();
      reset         = 1'b0;
      start_port[1] = 1'b1;
      op_port[1]    = 1'b0;
      step();
      start_port = '0;
      chk("rst2_now_ms", now_ms, 0);
      chk("rst2_done", done_port, 0);
      chk("rst2_return", return_port, 0);
      reset = 1'b1;
      k     = 0;
      start_port = 4'b1001;
      op_port    = 4'b0000;
      step();
      start_port = '0;
      chk("rst2_k1", done_port, 4'b0000);
      step(); chk("rst2_rr_first", done_port, 4'b0001);
      step(); chk("rst2_rr_second", done_port, 4'b1000);
      quiet_count(4'b1111, 220, cnt);
      chk("rst2_quiet", cnt, 0);
      chk("rst2_now_22", now_ms, 32'd22);

      // now_ms wrap: SLEEP 4 from 32'hFFFFFFFE completes at now_ms=2
      force dut.u_tick_gen.now_ms_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_tick_gen.now_ms_q;
      start_port[1]      = 1'b1;
      op_port[1]         = 1'b1;
      arg_port[32 +: 32] = 32'd4;
      step();
      start_port = '0;
      chk("wrap_now", now_ms, 32'hFFFF_FFFE);
      wait_done("wrap", 4'b0010, 60, seen);
      chk("wrap_k", k, 261);
      chk("wrap_ret", return_port[63:32], 32'd2);

      // oversized SLEEP is clamped, so it must not complete soon
      start_port[3]      = 1'b1;
      op_port[3]         = 1'b1;
      arg_port[96 +: 32] = 32'hFFFF_FFFF;
      step();
      start_port = '0;
      quiet_count(4'b1000, 300, cnt);
      chk("clamp_quiet", cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
